// File: rtl/data_sync_pkg.sv
// data_sync_pkg: shared limits and helpers for the data_sync CDC receiver.
package data_sync_pkg;
  localparam int DS_MIN_STAGES = 2;
  localparam int DS_MAX_STAGES = 8;
  function automatic int ds_cnt_w(input int min_gap);
    return $clog2(min_gap + 1);
  endfunction
endpackage

// File: rtl/data_sync_pulse_gen.sv
// data_sync_pulse_gen: enable synchronizer chain plus rising-edge detector.
module data_sync_pulse_gen
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic BUS_ENABLE,
  output logic o_pulse
);
  logic [NUM_STAGES-1:0] r_stages;
  logic                  r_prev;
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      r_stages <= '0;
      r_prev   <= 1'b0;
    end else begin
      r_stages <= {r_stages[NUM_STAGES-2:0], BUS_ENABLE};
      r_prev   <= r_stages[NUM_STAGES-1];
    end
  assign o_pulse = r_stages[NUM_STAGES-1] & ~r_prev;
endmodule

// File: rtl/data_sync.sv
// data_sync: multi-bit CDC receiver capturing UNSYNC_BUS on a synchronized enable edge.
// Define DATA_SYNC_OVR_EN to add the OVR_CLR/OVERRUN too-close-capture monitor.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int MIN_GAP    = 4
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE
`ifdef DATA_SYNC_OVR_EN
  ,
  input  logic                 OVR_CLR,
  output logic                 OVERRUN
`endif
);
  generate
    if (NUM_STAGES < DS_MIN_STAGES || NUM_STAGES > DS_MAX_STAGES || BUS_WIDTH < 1 || MIN_GAP < 1) begin : g_bad_cfg
      $error("data_sync: illegal parameters NUM_STAGES=%0d BUS_WIDTH=%0d MIN_GAP=%0d", NUM_STAGES, BUS_WIDTH, MIN_GAP);
    end
  endgenerate
  logic w_pulse;
  data_sync_pulse_gen #(.NUM_STAGES(NUM_STAGES)) u_pulse_gen (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .BUS_ENABLE(BUS_ENABLE),
    .o_pulse   (w_pulse)
  );
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
    end else begin
      SYNC_BUS     <= w_pulse ? UNSYNC_BUS : SYNC_BUS;
      ENABLE_PULSE <= w_pulse;
    end
`ifdef DATA_SYNC_OVR_EN
  localparam int CW = ds_cnt_w(MIN_GAP);
  logic [CW-1:0] r_gap;
  // Counter starts saturated so the first capture after reset never flags.
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      r_gap   <= CW'(MIN_GAP);
      OVERRUN <= 1'b0;
    end else begin
      r_gap   <= w_pulse ? '0 : (r_gap == CW'(MIN_GAP)) ? r_gap : r_gap + 1'b1;
      OVERRUN <= (w_pulse && r_gap < CW'(MIN_GAP - 1)) ? 1'b1 : OVR_CLR ? 1'b0 : OVERRUN;
    end
`endif
endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: directed table-driven bench for data_sync plus random async enable toggling.
module tb_data_sync;
  logic       CLK;
  logic       RST_n;
  logic [7:0] UNSYNC_BUS;
  logic       BUS_ENABLE;
  logic [7:0] SYNC_BUS;
  logic       ENABLE_PULSE;
`ifdef DATA_SYNC_OVR_EN
  logic       OVR_CLR;
  logic       OVERRUN;
`endif
  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .MIN_GAP(4)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .UNSYNC_BUS  (UNSYNC_BUS),
    .BUS_ENABLE  (BUS_ENABLE),
    .SYNC_BUS    (SYNC_BUS),
    .ENABLE_PULSE(ENABLE_PULSE)
`ifdef DATA_SYNC_OVR_EN
    ,
    .OVR_CLR     (OVR_CLR),
    .OVERRUN     (OVERRUN)
`endif
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  typedef struct {
    logic       en;
    logic [7:0] bus;
    logic       exp_p;
    logic [7:0] exp_s;
  } vec_t;
  vec_t       vecs[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic       mon_on = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  always @(negedge CLK)
    if (mon_on && ENABLE_PULSE === 1'b1) got_q.push_back(SYNC_BUS);
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    RST_n = 1'b0;
    BUS_ENABLE = 1'b0;
    UNSYNC_BUS = 8'h00;
`ifdef DATA_SYNC_OVR_EN
    OVR_CLR = 1'b0;
`endif
    // Tests 1-3: rise/capture, held-high with bus change, fall then second rise.
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 8'hA5});
    for (int i = 3; i < 20; i++) vecs.push_back('{1'b1, (i < 10) ? 8'hA5 : 8'h3C, 1'b0, 8'hA5});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 8'h3C, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 8'h3C, 1'b1, 8'h3C});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 8'h3C});
    tick();
    tick();
    chk("reset_sync_bus", 32'(SYNC_BUS), 32'h00);
    chk("reset_pulse", 32'(ENABLE_PULSE), 32'h0);
`ifdef DATA_SYNC_OVR_EN
    chk("reset_overrun", 32'(OVERRUN), 32'h0);
`endif
    RST_n = 1'b1;
    foreach (vecs[i]) begin
      BUS_ENABLE = vecs[i].en;
      UNSYNC_BUS = vecs[i].bus;
      tick();
      chk($sformatf("vec%0d_pulse", i), 32'(ENABLE_PULSE), 32'(vecs[i].exp_p));
      chk($sformatf("vec%0d_sync", i), 32'(SYNC_BUS), 32'(vecs[i].exp_s));
    end
    // Test 4: reset while an enable is in flight.
    BUS_ENABLE = 1'b0;
    repeat (4) tick();
    UNSYNC_BUS = 8'h5A;
    BUS_ENABLE = 1'b1;
    tick();
    #2 RST_n = 1'b0;
    #1;
    chk("midrst_sync_bus", 32'(SYNC_BUS), 32'h00);
    chk("midrst_pulse", 32'(ENABLE_PULSE), 32'h0);
    tick();
    RST_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rel_edge%0d_pulse", i), 32'(ENABLE_PULSE), 32'(i == 3));
      chk($sformatf("rel_edge%0d_sync", i), 32'(SYNC_BUS), (i >= 3) ? 32'h5A : 32'h00);
    end
`ifdef DATA_SYNC_OVR_EN
    // Test 5: pulses two cycles apart flag; clear; six cycles apart do not.
    BUS_ENABLE = 1'b0;
    repeat (6) tick();
    chk("ovr_idle", 32'(OVERRUN), 32'h0);
    UNSYNC_BUS = 8'h11;
    BUS_ENABLE = 1'b1;
    tick();
    BUS_ENABLE = 1'b0;
    tick();
    BUS_ENABLE = 1'b1;
    tick();
    chk("ovr_first_pulse", 32'(ENABLE_PULSE), 32'h1);
    chk("ovr_first_data", 32'(SYNC_BUS), 32'h11);
    chk("ovr_first_noflag", 32'(OVERRUN), 32'h0);
    UNSYNC_BUS = 8'h22;
    repeat (6) tick();
    chk("ovr_set", 32'(OVERRUN), 32'h1);
    chk("ovr_second_data", 32'(SYNC_BUS), 32'h22);
    repeat (3) tick();
    chk("ovr_sticky", 32'(OVERRUN), 32'h1);
    OVR_CLR = 1'b1;
    tick();
    OVR_CLR = 1'b0;
    chk("ovr_clr", 32'(OVERRUN), 32'h0);
    BUS_ENABLE = 1'b0;
    repeat (4) tick();
    UNSYNC_BUS = 8'h33;
    BUS_ENABLE = 1'b1;
    repeat (3) tick();
    BUS_ENABLE = 1'b0;
    repeat (3) tick();
    UNSYNC_BUS = 8'h44;
    BUS_ENABLE = 1'b1;
    repeat (10) tick();
    chk("ovr_wide_gap", 32'(OVERRUN), 32'h0);
    chk("ovr_wide_data", 32'(SYNC_BUS), 32'h44);
`endif
    // Test 6: random asynchronous toggles with long holds.
    BUS_ENABLE = 1'b0;
    repeat (6) tick();
    mon_on = 1'b1;
    for (int it = 0; it < 500; it++) begin
      @(posedge CLK);
      #($urandom_range(1, 9));
      if (!BUS_ENABLE) begin
        UNSYNC_BUS = 8'($urandom);
        BUS_ENABLE = 1'b1;
        exp_q.push_back(UNSYNC_BUS);
      end else begin
        BUS_ENABLE = 1'b0;
      end
      repeat ($urandom_range(8, 12)) @(posedge CLK);
    end
    repeat (10) tick();
    mon_on = 1'b0;
    chk("rand_pulse_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rand_capture%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
